// File: rtl/mem_stream_loader_pkg.sv
// mem_stream_loader shared package.
// Loader state encoding and target memory geometry.
package mem_stream_loader_pkg;

  localparam int DEPTH          = 6144;
  localparam int ADDR_W         = 13;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_stream_loader_byte_packer.sv
// Little-endian byte-to-word packer.
// Holds lane index, word accumulator and byteenable.
module mem_stream_loader_byte_packer
  import mem_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [3:0]  be,
  output logic        word_full
);

  logic [1:0] lane;

  // Next push lands in the top lane and completes the word.
  assign word_full = (lane == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane <= '0;
      word <= '0;
      be   <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
      be   <= '0;
    end else if (push) begin
      word[{lane, 3'b000} +: 8] <= data;
      be[lane]                  <= 1'b1;
      lane                      <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/mem_stream_loader.sv
// Stream-to-memory loader: packs bytes into words
// and writes them over an Avalon-MM master port.
module mem_stream_loader #(
  parameter int ADDR_W = mem_stream_loader_pkg::ADDR_W,
  parameter int DEPTH  = mem_stream_loader_pkg::DEPTH,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import mem_stream_loader_pkg::*;

  state_e             state;
  logic [LEN_W-1:0]   remaining;
  logic               wr_q;
  logic               accept;
  logic               pk_clear;
  logic               word_full;
  logic [31:0]        words;
  logic [31:0]        end_addr;
  logic               range_bad;

  assign accept         = in_valid & in_ready;
  assign mem_chipselect = wr_q;
  assign mem_write      = wr_q;

  assign pk_clear = (state == ST_WRITE)
                  | ((state == ST_FILL) & abort)
                  | ((state == ST_IDLE) & start);

  // Last word written is base + words - 1, so this also rules out wrap.
  always_comb begin
    words = (32'(byte_count) + 32'(BYTES_PER_WORD - 1))
          / 32'(BYTES_PER_WORD);
    end_addr  = 32'(base_addr) + words;
    range_bad = (32'(base_addr) >= 32'(DEPTH))
              || (end_addr > 32'(DEPTH));
  end

  mem_stream_loader_byte_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (pk_clear),
    .push      (accept),
    .data      (in_data),
    .word      (mem_writedata),
    .be        (mem_byteenable),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      mem_address <= '0;
      remaining   <= '0;
      in_ready    <= 1'b0;
      wr_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      wr_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (range_bad) begin
              err <= 1'b1;
            end else if (byte_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b1;
            end else begin
              state       <= ST_FILL;
              mem_address <= base_addr;
              remaining   <= byte_count;
              in_ready    <= 1'b1;
              busy        <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (abort) begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (accept) begin
            remaining <= remaining - 1'b1;
            if (word_full || remaining == LEN_W'(1)) begin
              state    <= ST_WRITE;
              in_ready <= 1'b0;
              wr_q     <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          mem_address <= mem_address + 1'b1;
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (remaining != '0) begin
            state    <= ST_FILL;
            in_ready <= 1'b1;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Self-checking bench for mem_stream_loader.
// Write stream is compared against a byte-level packing model.
module tb_mem_stream_loader;

  localparam int DEPTH = 6144;

  typedef struct packed {
    logic [12:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [12:0] base_addr = '0;
  logic [15:0] byte_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  wr_t wq[$];
  logic [7:0] stim[$];

  mem_stream_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .byte_count     (byte_count),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (mem_write) begin
      wq.push_back({mem_address, mem_byteenable, mem_writedata});
      check("cs_with_write", 64'(mem_chipselect), 64'd1);
      check("ready_in_write", 64'(in_ready), 64'd0);
    end
  end

  task automatic chk_zero(input string t);
    check({t, "_flags"}, 64'({in_ready, busy, done, err}), 64'd0);
    check({t, "_memctl"}, 64'({mem_chipselect, mem_write,
                               mem_byteenable, mem_address}), 64'd0);
    check({t, "_wdata"}, 64'(mem_writedata), 64'd0);
  endtask

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  task automatic feed(input int n, input bit gaps);
    int i = 0;
    int t = 0;
    bit ph = 1'b0;
    while (i < n && t < 2000) begin
      @(negedge clk);
      ph = ~ph;
      in_valid = gaps ? ph : 1'b1;
      in_data = stim[i];
      if (in_valid && in_ready) i++;
      t++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("feed_accepted", 64'(i), 64'(n));
  endtask

  task automatic expect_writes(input logic [12:0] base, input int n);
    int nw = (n + 3) / 4;
    check("write_count", 64'(wq.size()), 64'(nw));
    for (int w = 0; w < nw && w < wq.size(); w++) begin
      logic [31:0] d = '0;
      logic [3:0] be = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) begin
          d = d | (32'(stim[4 * w + k]) << (8 * k));
          be[k] = 1'b1;
        end
      end
      check("wr_addr", 64'(wq[w].a), 64'(int'(base) + w));
      check("wr_be", 64'(wq[w].be), 64'(be));
      check("wr_data", 64'(wq[w].d), 64'(d));
    end
  endtask

  task automatic do_load(input logic [12:0] base, input int n,
                         input bit gaps);
    int nw = (n + 3) / 4;
    bit ok = (int'(base) < DEPTH) && (int'(base) + nw <= DEPTH);
    int t = 0;
    wq.delete();
    done_cnt = 0;
    err_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    byte_count = 16'(n);
    @(negedge clk);
    start = 1'b0;
    if (!ok) begin
      check("err_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      check("err_cnt", 64'(err_cnt), 64'd1);
      check("err_writes", 64'(wq.size()), 64'd0);
      check("err_done", 64'(done_cnt), 64'd0);
      return;
    end
    check("busy_on", 64'(busy), 64'd1);
    if (n > 0) feed(n, gaps);
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done), 64'd1);
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_cnt", 64'(done_cnt), 64'd1);
    check("err_cnt_ok", 64'(err_cnt), 64'd0);
    expect_writes(base, n);
  endtask

  initial begin
    int n;
    int nw;
    logic [12:0] b;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_load(13'h010, 8, 1'b0);

    stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    do_load(13'h000, 6, 1'b0);

    rand_stim(8);
    do_load(13'h17FF, 8, 1'b0);
    rand_stim(4);
    do_load(13'h17FF, 4, 1'b0);

    stim.delete();
    do_load(13'h100, 0, 1'b0);

    rand_stim(11);
    do_load(13'h200, 11, 1'b1);

    // abort after two of four bytes
    rand_stim(4);
    wq.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = 13'h020;
    byte_count = 16'd4;
    @(negedge clk);
    start = 1'b0;
    feed(2, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_writes", 64'(wq.size()), 64'd0);
    check("abort_done", 64'(done_cnt), 64'd0);
    rand_stim(7);
    do_load(13'h300, 7, 1'b0);

    // reset pulled mid-fill
    rand_stim(8);
    wq.delete();
    @(negedge clk);
    start = 1'b1;
    base_addr = 13'h040;
    byte_count = 16'd8;
    @(negedge clk);
    start = 1'b0;
    feed(3, 1'b0);
    #1 reset_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_writes", 64'(wq.size()), 64'd0);
    rand_stim(9);
    do_load(13'h050, 9, 1'b1);

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(0, 24);
      nw = (n + 3) / 4;
      if (r % 2 == 0) b = 13'(DEPTH - nw - 2 + $urandom_range(0, 4));
      else b = 13'($urandom_range(0, 8191));
      rand_stim(n);
      do_load(b, n, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Avalon-MM write master that sits directly upstream of the 6144 x 32-bit on-chip program/data memory (s1 port).
- Accepts a byte stream from the IoT link, for example the UART receiver, using valid/ready.
- Packs bytes little-endian into 32-bit words and writes them to a configured base word address.
- Uses byteenable for a trailing partial word and reports done or error to the control FSM.

Parameters:
- ADDR_W, 13, word-address width of the target memory.
- DEPTH, 6144, number of 32-bit words in the target memory.
- LEN_W, 16, width of the byte-count input; must cover DEPTH*4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches a load; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current load.
- base_addr  in  ADDR_W  first word address, latched at start.
- byte_count  in  LEN_W  number of bytes to load, latched at start.
- in_data  in  8  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader can accept a byte.
- mem_address  out  ADDR_W  word address driven to the memory.
- mem_byteenable  out  4  lane enables; bit i covers writedata[8i+7:8i].
- mem_chipselect  out  1  memory select.
- mem_write  out  1  write strobe.
- mem_writedata  out  32  packed word.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse when all bytes have been written.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (reset_n low, asynchronous): state goes to IDLE. All outputs are 0, including in_ready, busy, done, err and the mem_* signals. The byte counter, lane index and word register are cleared.
- States: IDLE, FILL, WRITE, DONE.
- IDLE, start=1:
  - Compute words = ceil(byte_count/4).
  - If base_addr >= DEPTH, or base_addr + words > DEPTH: pulse err for 1 cycle and stay in IDLE.
  - Else if byte_count == 0: go to DONE with no memory write.
  - Else latch base_addr and byte_count, clear the lane index, and go to FILL.
- A start pulse outside IDLE is ignored.
- FILL:
  - in_ready = 1.
  - A byte is accepted on a cycle with in_valid & in_ready. It is stored in lane = lane index, its byteenable bit is set, and remaining is decremented.
  - Go to WRITE when lane 3 has been filled or when remaining reaches 0.
- WRITE (exactly 1 cycle):
  - in_ready = 0; mem_chipselect = mem_write = 1.
  - mem_address = current address; byteenable = the accumulated lanes; unfilled lanes of writedata are 0.
  - The memory has no waitrequest, so the write completes in this cycle.
  - Next cycle: address increments by 1 and the lane register and enables clear. Go to FILL if remaining > 0, else go to DONE.
- DONE (1 cycle): done = 1. Next cycle busy = 0 and state returns to IDLE.
- Throughput is 5 cycles per full word: 4 accepted bytes plus 1 write cycle.
- abort:
  - In FILL or WRITE: next state is IDLE. A partial word is discarded; a write already being driven in the WRITE cycle still completes.
  - No done pulse is generated. abort has no effect in IDLE.
- Address wrap cannot occur, because the range check at start guarantees the last address is at most DEPTH-1.
- Reset asserted mid-load: the load is abandoned immediately. Memory contents already written remain.
- mem_* outputs are registered; mem_chipselect and mem_write are never high outside WRITE.

Decomposition:
- Shared package: the state encoding (IDLE, FILL, WRITE, DONE) and the constants DEPTH, ADDR_W, BYTES_PER_WORD = 4.
- One sub-module is natural: byte_packer, which holds the lane index, 32-bit accumulator and byteenable, and exposes a word_full flag and a clear input.
- The FSM, counters and range check stay in the top module.

Test Plan:
- Full-word load: base=0x010, count=8, bytes 11 22 33 44 55 66 77 88. Required: writes of 0x44332211 to address 0x010 and 0x88776655 to 0x011, both with be=F; then a done pulse.
- Partial tail: base=0x000, count=6, bytes A0..A5. Required: word 0 = 0xA3A2A1A0 with be=F; word 1 has be=0x3 and writedata=0x0000A5A4; then done.
- Range error: base=6143 (0x17FF), count=8, i.e. 2 words. Required: err pulses, busy stays 0, no memory write. Repeat with count=4: one write to address 0x17FF.
- Zero length and backpressure: count=0 gives done with no write. A stream with in_valid toggling 1-0-1 gives the same packed words; in_ready is low during every WRITE cycle.
- Abort: abort after 2 of 4 bytes. Required: no write, no done, return to IDLE; a following start succeeds.
- Mid-load reset: reset_n pulled low in FILL. Required: all outputs 0 asynchronously, and a following start loads normally.
